// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types, widths and round-robin pick helper for mult_arbiter
package mult_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mult_arb_state_e;

    localparam int OPW  = 32;
    localparam int RESW = 64;

    // Requester vectors are zero-extended to 8 bits, so wrapping mod 8 visits
    // the same live requesters in the same order as wrapping mod NREQ.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr);
        logic [2:0] idx;
        rr_pick = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a supplied pointer
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      grant_idx,
    output logic            grant_valid
);

    logic [7:0] req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        grant_idx           = rr_pick(req_ext, ptr);
        grant_valid         = enable && (|req);
        grant               = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grant_valid && (grant_idx == 3'(i));
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one sequential multiplier with a watchdog
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NCLOCKS = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*OPW-1:0]  req_a_i,
    input  logic [NREQ*OPW-1:0]  req_b_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [RESW-1:0]      rsp_result_o,
    output logic                 rsp_err_o,
    output logic [OPW-1:0]       mul_a_o,
    output logic [OPW-1:0]       mul_b_o,
    output logic [31:0]          mul_nclocks_o,
    output logic                 mul_in_valid_o,
    input  logic                 mul_in_ready_i,
    output logic                 mul_out_ready_o,
    input  logic [RESW-1:0]      mul_result_i,
    input  logic                 mul_out_valid_i
);

    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [2:0]     PTR_LAST = 3'(NREQ - 1);

    mult_arb_state_e state, state_d;
    logic [2:0]      rr_ptr;
    logic [2:0]      grant_idx;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] owner_oh;
    logic            grant_valid;
    logic [OPW-1:0]  a_q, b_q, sel_a, sel_b;
    logic [RESW-1:0] result_q;
    logic            err_q;
    logic [WDW-1:0]  wdog;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req         (req_valid_i),
        .ptr         (rr_ptr),
        .enable      (state == IDLE),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a_i[i*OPW +: OPW];
                sel_b = req_b_i[i*OPW +: OPW];
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant_valid) state_d = ISSUE;
            ISSUE:   if (mul_in_ready_i) state_d = WAIT;
            WAIT:    if (mul_out_valid_i || (wdog == WD_LAST)) state_d = RESP;
            RESP:    if (|(rsp_ready_i & owner_oh)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A result arriving on the timeout cycle wins over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner_oh <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wdog     <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (grant_valid) begin
                    a_q      <= sel_a;
                    b_q      <= sel_b;
                    owner_oh <= grant;
                    rr_ptr   <= (grant_idx == PTR_LAST) ? 3'd0 : grant_idx + 3'd1;
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + WDW'(1);
                    if (mul_out_valid_i) begin
                        result_q <= mul_result_i;
                        err_q    <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o     = grant;
    assign rsp_valid_o     = (state == RESP) ? owner_oh : '0;
    assign rsp_result_o    = result_q;
    assign rsp_err_o       = (state == RESP) && err_q;
    assign mul_a_o         = a_q;
    assign mul_b_o         = b_q;
    assign mul_nclocks_o   = 32'(NCLOCKS);
    assign mul_in_valid_o  = (state == ISSUE);
    assign mul_out_ready_o = (state == ISSUE) || (state == WAIT);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench with stub multiplier and transaction model
module tb_mult_arbiter;

    localparam int NREQ    = 2;
    localparam int NCLOCKS = 32;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready_o;
    logic [NREQ*32-1:0]   req_a, req_b;
    logic [NREQ-1:0]      rsp_valid_o, rsp_ready;
    logic [63:0]          rsp_result_o;
    logic                 rsp_err_o;
    logic [31:0]          mul_a_o, mul_b_o, mul_nclocks_o;
    logic                 mul_in_valid_o, mul_out_ready_o;
    logic                 st_in_ready, st_out_valid;
    logic [63:0]          st_result;
    int                   st_cnt;
    logic                 hang;

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(NREQ), .NCLOCKS(NCLOCKS), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result_o),
        .rsp_err_o       (rsp_err_o),
        .mul_a_o         (mul_a_o),
        .mul_b_o         (mul_b_o),
        .mul_nclocks_o   (mul_nclocks_o),
        .mul_in_valid_o  (mul_in_valid_o),
        .mul_in_ready_i  (st_in_ready),
        .mul_out_ready_o (mul_out_ready_o),
        .mul_result_i    (st_result),
        .mul_out_valid_i (st_out_valid)
    );

    // Stub multiplier: result sticky NCLOCKS edges after start; hang delays it past the watchdog.
    always @(posedge clk) begin
        if (rst) begin
            st_in_ready  <= 1'b1;
            st_out_valid <= 1'b0;
            st_cnt       <= 0;
            st_result    <= '0;
        end else if (mul_in_valid_o && st_in_ready && mul_out_ready_o) begin
            st_in_ready  <= 1'b0;
            st_out_valid <= 1'b0;
            st_cnt       <= hang ? 100 : NCLOCKS;
            st_result    <= 64'(mul_a_o) * 64'(mul_b_o);
        end else if (st_cnt != 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) begin
                st_out_valid <= 1'b1;
                st_in_ready  <= 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model
    logic            m_busy, m_seen, m_err;
    logic [NREQ-1:0] m_owner, m_exp_ready, m_exp_rv;
    logic [31:0]     m_a, m_b;
    logic [63:0]     m_res, last_result;
    logic            last_err;
    int              m_ptr, m_pick, m_idx, m_lat, m_acc;
    int              n_acc = 0, n_rsp = 0, n_seen = 0;
    int              last_lat, last_hs, last_acc;
    int              grant_log[$];

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_seen = 1'b0;
            m_ptr  = 0;
        end else begin
            m_pick      = -1;
            m_exp_ready = '0;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (m_ptr + k) % NREQ;
                    if (m_pick < 0 && req_valid[m_idx]) m_pick = m_idx;
                end
            end
            if (m_pick >= 0) m_exp_ready[m_pick] = 1'b1;
            chk("req_ready", 64'(req_ready_o), 64'(m_exp_ready));

            m_exp_rv = '0;
            if (m_busy) begin
                if (m_seen || (m_lat >= 0 && cyc - m_acc >= m_lat)) m_exp_rv = m_owner;
                else if (m_lat < 0 && rsp_valid_o != '0) m_exp_rv = m_owner;
                chk("mul_a", 64'(mul_a_o), 64'(m_a));
                chk("mul_b", 64'(mul_b_o), 64'(m_b));
            end
            chk("rsp_valid", 64'(rsp_valid_o), 64'(m_exp_rv));

            if (m_exp_rv != '0 && rsp_valid_o == m_exp_rv) begin
                chk("rsp_result", rsp_result_o, m_res);
                chk("rsp_err", 64'(rsp_err_o), 64'(m_err));
                if (!m_seen) begin
                    m_seen   = 1'b1;
                    n_seen++;
                    last_lat = cyc - m_acc;
                end
                if ((rsp_ready & m_exp_rv) != '0) begin
                    m_busy      = 1'b0;
                    n_rsp++;
                    last_result = rsp_result_o;
                    last_err    = rsp_err_o;
                    last_hs     = cyc + 1;
                end
            end

            if (m_pick >= 0 && req_ready_o == m_exp_ready) begin
                m_busy  = 1'b1;
                m_seen  = 1'b0;
                m_owner = m_exp_ready;
                m_a     = req_a[m_pick*32 +: 32];
                m_b     = req_b[m_pick*32 +: 32];
                m_res   = hang ? 64'd0 : 64'(m_a) * 64'(m_b);
                m_err   = hang;
                m_lat   = !st_in_ready ? -1 : (hang ? TIMEOUT + 1 : NCLOCKS + 2);
                m_acc   = cyc + 1;
                m_ptr   = (m_pick + 1) % NREQ;
                last_acc = cyc + 1;
                grant_log.push_back(m_pick);
                n_acc++;
            end
        end
    end

    task automatic wait_accepts(input int target);
        int k = 0;
        while (n_acc < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("accept_count", 64'(n_acc), 64'(target));
    endtask

    task automatic wait_rsps(input int target);
        int k = 0;
        while (n_rsp < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("response_count", 64'(n_rsp), 64'(target));
    endtask

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i]      = 1'b1;
        wait_accepts(n_acc + 1);
        req_valid[i]      = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        chk({tag, "_rsp_result"}, rsp_result_o, 64'd0);
        chk({tag, "_in_valid"}, 64'(mul_in_valid_o), 64'd0);
        chk({tag, "_out_ready"}, 64'(mul_out_ready_o), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a_o), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b_o), 64'd0);
        chk({tag, "_nclocks"}, 64'(mul_nclocks_o), 64'd32);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        hang      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(0, 32'h0000_0003, 32'h0000_0005);
        wait_rsps(1);
        chk("single_result", last_result, 64'h0F);
        chk("single_err", 64'(last_err), 64'd0);
        chk("single_latency", 64'(last_lat), 64'd34);

        send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsps(2);
        chk("max_result", last_result, 64'hFFFF_FFFE_0000_0001);

        grant_log.delete();
        req_a[31:0]  = 32'd7;       req_b[31:0]  = 32'd9;
        req_a[63:32] = 32'h1_0000;  req_b[63:32] = 32'h1_0000;
        req_valid    = 2'b11;
        wait_accepts(n_acc + 4);
        req_valid = '0;
        wait_rsps(6);
        chk("rr_count", 64'(grant_log.size()), 64'd4);
        for (int g = 0; g < 4; g++) begin
            k = (g < grant_log.size()) ? grant_log[g] : 99;
            chk($sformatf("rr_grant%0d", g), 64'(k), 64'(g % 2));
        end
        chk("rr_last_result", last_result, 64'h1_0000_0000);

        rsp_ready = 2'b10;
        send(0, 32'h1234_5678, 32'h9ABC_DEF0);
        req_a[63:32] = 32'd5;
        req_b[63:32] = 32'd11;
        req_valid[1] = 1'b1;
        k = 0;
        while (n_seen < 7 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("bp_still_pending", 64'(n_rsp), 64'd6);
        rsp_ready = 2'b11;
        wait_accepts(n_acc + 1);
        req_valid[1] = 1'b0;
        chk("bp_idle_next", 64'(last_acc - last_hs), 64'd1);
        wait_rsps(8);
        chk("bp_next_result", last_result, 64'd55);

        hang = 1'b1;
        send(0, 32'd2, 32'd3);
        wait_rsps(9);
        chk("timeout_err", 64'(last_err), 64'd1);
        chk("timeout_result", last_result, 64'd0);
        chk("timeout_latency", 64'(last_lat), 64'd65);
        hang = 1'b0;
        send(1, 32'd7, 32'd6);
        wait_rsps(10);
        chk("post_timeout_result", last_result, 64'd42);
        chk("post_timeout_err", 64'(last_err), 64'd0);

        send(0, 32'd100, 32'd200);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("mid_wait_reset");
        repeat (40) @(posedge clk);
        #1;
        chk("reset_no_response", 64'(n_rsp), 64'd10);
        send(1, 32'h1234, 32'h10);
        wait_rsps(11);
        chk("after_reset_result", last_result, 64'h1_2340);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin controller that shares one 32x32 sequential multiplier (the `booth_multiplier_32x32` handshake: operands plus `nclocks`, `in_valid`/`in_ready`, 64-bit result with `out_valid`/`out_ready`) among NREQ requesters. It accepts one request at a time, issues it to the multiplier and waits for completion. It returns the 64-bit unsigned product to the owning requester, and flags an error if the multiplier exceeds a cycle budget. It sits between the execution-stage requesters (e.g. MUL and DIV-assist ports) and the single multiplier instance.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- NCLOCKS, 32, value driven on `mul_nclocks_o` (1..32)
- TIMEOUT, 64, maximum cycles in WAIT before error (must be > NCLOCKS+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester accept; one-hot or zero
- req_a_i  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_b_i  in  NREQ*32  operand B, same packing
- rsp_valid_o  out  NREQ  result valid to owner; one-hot or zero
- rsp_ready_i  in  NREQ  owner accepts result
- rsp_result_o  out  64  product, shared by all requesters
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o
- mul_a_o, mul_b_o  out  32  operands to multiplier
- mul_nclocks_o  out  32  constant NCLOCKS
- mul_in_valid_o  out  1  start request to multiplier
- mul_in_ready_i  in  1  multiplier idle
- mul_out_ready_o  out  1  controller can take a result; multiplier start also needs it high
- mul_result_i  in  64  multiplier product
- mul_out_valid_i  in  1  multiplier result valid; sticky until next start

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The round-robin arbiter picks the first valid requester at or after `rr_ptr`.
  - `req_ready_o[g]`=1 combinationally, for the grant only.
  - On that edge: latch A, B and owner index g; set `rr_ptr`=(g+1) mod NREQ; go to ISSUE.
- ISSUE:
  - `mul_in_valid_o`=1 and `mul_out_ready_o`=1.
  - Stay in ISSUE until `mul_in_ready_i`=1, then go to WAIT with `wdog`=0.
- WAIT:
  - `mul_out_ready_o`=1; `wdog` increments each cycle.
  - If `mul_out_valid_i`=1: capture `mul_result_i`, set err=0, go to RESP.
  - Else if `wdog`==TIMEOUT-1: set result=0, err=1, go to RESP.
  - A simultaneous valid and timeout resolves as valid.
- RESP:
  - `rsp_valid_o[owner]`=1, holding result and err stable.
  - On `rsp_ready_i[owner]`, go to IDLE.
  - `rsp_ready_i` of non-owners is ignored.
- `mul_out_valid_i` is only sampled in WAIT. A late result after a timeout is discarded, and the next ISSUE waits on `mul_in_ready_i`.
- `mul_a_o`/`mul_b_o` hold the latched operands in all states.
- Request operands need only be stable on the accept edge.

## Timing
- Reset values:
  - `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `mul_in_valid_o`, `mul_out_ready_o` = 0.
  - `rsp_result_o`, `mul_a_o`, `mul_b_o` = 0.
  - `mul_nclocks_o` = NCLOCKS.
  - state = IDLE, `rr_ptr` = 0, `wdog` = 0.
- Reset is synchronous: `rst` high at an edge overrides all transitions. Reset mid-operation drops the in-flight request with no response. The multiplier's reset must be asserted concurrently at integration.
- Latency with an idle multiplier:
  - Accept edge E0; issue handshake at E1.
  - Multiplier valid after E1+NCLOCKS.
  - `rsp_valid_o` high after E2+NCLOCKS, i.e. NCLOCKS+2 cycles after accept (34 for default).
- Throughput: no request is accepted while not in IDLE. The earliest next accept is the cycle after the response handshake.
- Fairness: every requester held valid is granted within NREQ transactions.

## Structure
- Package `mult_arb_pkg`:
  - `mult_arb_state_e` enum (IDLE, ISSUE, WAIT, RESP).
  - Width constant `OPW`=32 and `RESW`=64.
  - Function `rr_pick(valid, ptr)`.
- Sub-module `rr_arbiter` (NREQ; inputs req vector, ptr, enable; outputs one-hot grant and index). It is purely combinational; `rr_ptr` stays in `mult_arbiter`.
- Watchdog width: `$clog2(TIMEOUT+1)`.

## Test plan
- Single request: req0 A=0x0000_0003, B=0x0000_0005 -> `rsp_valid_o`=01 after 34 cycles, result=0x0F, err=0.
- Max operands: A=B=0xFFFF_FFFF -> result=0xFFFF_FFFE_0000_0001.
- Contention: req0 and req1 held valid from reset -> grants alternate 0,1,0,1; each result returns only to its owner's `rsp_valid_o` bit.
- Response backpressure: hold `rsp_ready_i`=0 for 10 cycles -> `rsp_valid_o` and result stay stable, no new `req_ready_o`; release -> IDLE the next cycle.
- Timeout: stub multiplier never raises `mul_out_valid_i` -> after 64 WAIT cycles `rsp_valid_o`=1, err=1, result=0; a later stub valid is ignored.
- Reset mid-WAIT: assert `rst` 1 cycle at cycle 10 of WAIT -> all outputs at reset values next cycle, no response; a fresh request then completes correctly.
